// File: rtl/cache_control_if.sv
// cache_control_if: CPU request/response and physical-memory line handshake bundle
//   mem_read/mem_write/mem_address : CPU request, held until mem_resp
//   mem_resp/mem_err               : one-cycle completion strobe, err = pmem timeout
//   pmem_read/pmem_write           : line request, held until pmem_resp
//   pmem_address                   : 16-byte aligned line address
//   pmem_resp                      : physical-memory completion strobe
//   modport slave  : the cache controller side
//   modport master : CPU + physical-memory side (requester of the controller)
interface cache_control_if;
    logic        mem_read, mem_write, mem_resp, mem_err;
    logic [15:0] mem_address;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [15:0] pmem_address;
    modport slave (
        input  mem_read, mem_write, mem_address, pmem_resp,
        output mem_resp, mem_err, pmem_read, pmem_write, pmem_address
    );
    modport master (
        output mem_read, mem_write, mem_address, pmem_resp,
        input  mem_resp, mem_err, pmem_read, pmem_write, pmem_address
    );
endinterface

// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the 2-way LC-3b cache (hit service, write-back, allocate)
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : CPU memory port and pmem line handshake
//   hit, dirty, wb_tag  : lookup result and LRU victim info from the datapath
//   write_enable        : merge CPU write into the hit line
//   control_load        : load the returned pmem line into the LRU way
//   hit/miss/wb_count   : saturating performance counters, present only when
//                         CACHE_PERF_CNT_EN is defined, otherwise tied to 0
//   PMEM_TIMEOUT        : max cycles per pmem state before erroring out (0 = never)
module cache_control #(
    parameter int PMEM_TIMEOUT = 256,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_control_if.slave       bus,
    input  logic                 hit,
    input  logic                 dirty,
    input  logic [8:0]           wb_tag,
    output logic                 write_enable,
    output logic                 control_load,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);
    localparam int WW = PMEM_TIMEOUT > 1 ? $clog2(PMEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(PMEM_TIMEOUT > 0 ? PMEM_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t        state, state_next;
    logic [WW-1:0] wait_cnt;
    logic          req, in_pmem, timeout;
    logic          unused_offset;

    assign unused_offset = ^bus.mem_address[3:0];
    assign req     = bus.mem_read | bus.mem_write;
    assign in_pmem = state == WRITEBACK || state == ALLOCATE;
    // Timeout fires on the last allowed cycle only if pmem still has not answered
    assign timeout = PMEM_TIMEOUT != 0 && in_pmem && !bus.pmem_resp && wait_cnt == WAIT_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= state_next != state ? '0 : in_pmem ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next       = state;
        bus.mem_resp     = 1'b0;
        bus.mem_err      = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        write_enable     = 1'b0;
        control_load     = 1'b0;
        case (state)
            IDLE: state_next = req ? COMPARE : IDLE;
            COMPARE: begin
                bus.mem_resp = req & hit;
                write_enable = req & hit & bus.mem_write;
                state_next   = !req || hit ? IDLE : dirty ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {wb_tag, bus.mem_address[6:4], 4'h0};
                state_next       = bus.pmem_resp ? (req ? ALLOCATE : IDLE) : timeout ? IDLE : WRITEBACK;
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {bus.mem_address[15:4], 4'h0};
                control_load     = bus.pmem_resp;
                state_next       = bus.pmem_resp ? (req ? COMPARE : IDLE) : timeout ? IDLE : ALLOCATE;
            end
        endcase
        if (timeout) begin
            bus.mem_resp = 1'b1;
            bus.mem_err  = 1'b1;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic refill;   // COMPARE entered straight from a fill: that hit is not a new hit
    logic hit_inc, miss_inc, wb_inc;
    assign hit_inc  = state == COMPARE && req && hit && !refill;
    assign miss_inc = state == COMPARE && (state_next == WRITEBACK || state_next == ALLOCATE);
    assign wb_inc   = state == WRITEBACK && bus.pmem_resp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            refill <= state == ALLOCATE && state_next == COMPARE;
            if (hit_inc && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (miss_inc && !(&miss_count)) miss_count <= miss_count + 1'b1;
            if (wb_inc && !(&wb_count)) wb_count <= wb_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed + randomized transaction checks of cache_control against a transaction-level model
module tb_cache_control;
    localparam int TO = 8;
    logic        clk = 0, rst_n = 0;
    logic        hit = 0, dirty = 0;
    logic [8:0]  wb_tag = '0;
    logic        write_enable, control_load;
    logic [15:0] hit_count, miss_count, wb_count;
    int          tests = 0, fails = 0;
    int          m_hit = 0, m_miss = 0, m_wb = 0;

    cache_control_if bus();

    cache_control #(.PMEM_TIMEOUT(TO), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .hit(hit), .dirty(dirty), .wb_tag(wb_tag),
        .write_enable(write_enable), .control_load(control_load),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {bus.mem_resp, bus.mem_err, bus.pmem_read, bus.pmem_write,
                  write_enable, control_load, bus.pmem_address}, 32'h0);
    endtask

    function automatic logic [31:0] cexp(input int m);
`ifdef CACHE_PERF_CNT_EN
        return m;
`else
        return 0;
`endif
    endfunction

    task automatic chk_cnt();
        chk("hit_count", 32'(hit_count), cexp(m_hit));
        chk("miss_count", 32'(miss_count), cexp(m_miss));
        chk("wb_count", 32'(wb_count), cexp(m_wb));
    endtask

    task automatic cyc();
        @(negedge clk);
        bus.pmem_resp = 0;
    endtask

    // One pmem state: pmem answers on cycle dly; dly > TO means it never answers
    task automatic phase(input bit wb, input int dly, input logic [15:0] a, input bit drop, output bit tmo);
        tmo = 0;
        for (int k = 1; k <= TO; k++) begin
            cyc();
            bus.pmem_resp = (k == dly);
            if (drop && k == 1) begin
                bus.mem_read  = 0;
                bus.mem_write = 0;
            end
            #1;
            chk(wb ? "wb_strobe" : "al_strobe", {bus.pmem_write, bus.pmem_read}, wb ? 2'b10 : 2'b01);
            chk("pmem_addr", bus.pmem_address, a);
            chk("control_load", control_load, !wb && k == dly);
            chk("timeout_resp", {bus.mem_resp, bus.mem_err}, (k == TO && k != dly) ? 2'b11 : 2'b00);
            if (k == dly) break;
            if (k == TO) tmo = 1;
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic h, input logic d,
                       input logic [8:0] t, input int wbd, input int ald, input bit drop);
        bit tmo = 0;
        cyc();
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
        hit = h; dirty = d; wb_tag = t;
        #1 chk_idle("req_idle");
        cyc();
        bus.pmem_resp = 1'($urandom);
        #1;
        chk("cmp_resp", {bus.mem_resp, bus.mem_err, write_enable}, h ? {2'b10, wr} : 3'b000);
        chk("cmp_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
        if (h) m_hit++;
        else begin
            m_miss++;
            if (d) begin
                phase(1, wbd, {t, a[6:4], 4'h0}, 0, tmo);
                if (!tmo) m_wb++;
            end
            if (!tmo) phase(0, ald, {a[15:4], 4'h0}, drop, tmo);
            if (!tmo && !drop) begin
                cyc();
                hit = 1;
                #1;
                chk("fill_resp", {bus.mem_resp, bus.mem_err, write_enable, control_load}, {2'b10, wr, 1'b0});
            end
        end
        cyc();
        bus.mem_read = 0; bus.mem_write = 0; hit = 0;
        #1;
        chk_idle("after_txn");
        chk_cnt();
    endtask

    initial begin
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = '0; bus.pmem_resp = 0;
        #1 chk_idle("in_reset");
        chk_cnt();
        cyc(); cyc();
        rst_n = 1;
        // Reset in the middle of an allocate
        cyc();
        bus.mem_read = 1; bus.mem_address = 16'h1234; hit = 0; dirty = 0;
        cyc(); cyc();
        #1 chk("pre_reset_pmem_read", bus.pmem_read, 1'b1);
        rst_n = 0;
        #1 chk_idle("reset_mid_alloc");
        m_hit = 0; m_miss = 0; m_wb = 0;
        chk_cnt();
        cyc();
        bus.mem_read = 0;
        rst_n = 1;
        // Directed cases: read hit right after reset release, write hit, both, misses, timeouts
        txn(1, 0, 16'h1234, 1, 0, 9'h000, 1, 1, 0);
        txn(0, 1, 16'hBEEF, 1, 0, 9'h000, 1, 1, 0);
        txn(1, 1, 16'h0042, 1, 0, 9'h000, 1, 1, 0);
        txn(1, 0, 16'h1234, 0, 0, 9'h000, 1, 5, 0);
        txn(1, 0, 16'h1234, 0, 1, 9'h0AB, 3, 4, 0);
        txn(1, 0, 16'h2468, 0, 0, 9'h000, 1, 99, 0);
        txn(0, 1, 16'h4444, 0, 1, 9'h1FF, 99, 1, 0);
        txn(1, 0, 16'h7777, 0, 0, 9'h000, 1, TO, 0);
        txn(0, 1, 16'h0F00, 0, 1, 9'h055, TO, 2, 0);
        txn(1, 0, 16'h0F00, 0, 0, 9'h000, 1, 3, 1);
        for (int i = 0; i < 60; i++) begin
            int op, wbd, ald;
            bit drop;
            op   = $urandom_range(0, 2);
            wbd  = $urandom_range(1, TO + 1);
            ald  = $urandom_range(1, TO + 1);
            drop = ald <= TO && $urandom_range(0, 4) == 0;
            txn(op != 1, op != 0, 16'($urandom), 1'($urandom), 1'($urandom), 9'($urandom), wbd, ald, drop);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
